// File: rtl/day10_result_accumulator_pkg.sv
// Shared types and constants for the day10 result accumulator.
package day10_pkg;

    typedef enum logic [2:0] {
        ACCUMULATE,
        CONVERT,
        EMIT_DIGITS,
        EMIT_NEWLINE,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    // Decimal digits needed for a width-bit value (log10(2) ~ 0.30103).
    function automatic int num_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/day10_result_accumulator_if.sv
// AXI-stream style beat interface used for both the press-count input and ASCII output.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/day10_result_accumulator_bin_to_bcd.sv
// Iterative double-dabble converter: one bit per cycle, WIDTH cycles per conversion.
module bin_to_bcd_seq
    import day10_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = num_digits(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] adjusted;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                valid_q;

    always_comb begin
        adjusted = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adjusted[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                            : bcd_q[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start && !busy_q) begin
                bin_q  <= value;
                bcd_q  <= '0;
                cnt_q  <= CNT_W'(WIDTH);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q <= {adjusted[4*DIGITS-2:0], bin_q[WIDTH-1]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;

endmodule

// File: rtl/day10_result_accumulator.sv
// Sums per-machine press counts and emits the total as ASCII decimal plus newline.
// Optional build macro DAY10_ACCUM_SATURATE_EN clamps the total instead of wrapping.
module day10_result_accumulator
    import day10_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int SUM_WIDTH      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_stream_if.slave   data_in,
    axi_stream_if.master  data_out,
    output logic          overflow,
    output logic          done
);

    localparam int NUM_DIGITS = num_digits(SUM_WIDTH);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state_q, state_d;
    logic [SUM_WIDTH-1:0]    sum_q;
    logic [SUM_WIDTH:0]      add_full;
    logic [IDX_W-1:0]        dig_idx_q;
    logic [IDX_W-1:0]        first_idx;
    logic [3:0]              cur_digit;
    logic                    in_fire;
    logic                    out_fire;
    logic                    conv_start;
    logic                    conv_busy;
    logic                    conv_valid;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    assign in_fire   = data_in.tvalid && data_in.tready;
    assign out_fire  = data_out.tvalid && data_out.tready;
    assign add_full  = (SUM_WIDTH+1)'(sum_q) + (SUM_WIDTH+1)'(data_in.tdata);
    assign cur_digit = conv_bcd[{dig_idx_q, 2'b00} +: 4];

    bin_to_bcd_seq #(
        .WIDTH  (SUM_WIDTH),
        .DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (sum_q),
        .busy  (conv_busy),
        .valid (conv_valid),
        .bcd   (conv_bcd)
    );

    // Highest non-zero digit; stays 0 for a zero total so one '0' is still emitted.
    always_comb begin
        first_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (conv_bcd[4*i +: 4] != 4'd0) first_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACCUMULATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUMULATE:   if (in_fire && data_in.tlast) state_d = CONVERT;
            CONVERT:      if (conv_valid) state_d = EMIT_DIGITS;
            EMIT_DIGITS:  if (out_fire && dig_idx_q == '0) state_d = EMIT_NEWLINE;
            EMIT_NEWLINE: if (out_fire) state_d = DONE;
            DONE:         state_d = DONE;
            default:      state_d = ACCUMULATE;
        endcase
    end

    always_comb begin
        data_in.tready  = rst_n && (state_q == ACCUMULATE);
        data_out.tvalid = 1'b0;
        data_out.tdata  = '0;
        data_out.tlast  = 1'b0;
        done            = (state_q == DONE);
        // Converter kicks off in the first CONVERT cycle, once the final sum is registered.
        conv_start      = (state_q == CONVERT) && !conv_busy && !conv_valid;
        case (state_q)
            EMIT_DIGITS: begin
                data_out.tvalid = 1'b1;
                data_out.tdata  = ASCII_ZERO + {4'b0000, cur_digit};
            end
            EMIT_NEWLINE: begin
                data_out.tvalid = 1'b1;
                data_out.tdata  = ASCII_NEWLINE;
                data_out.tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            overflow  <= 1'b0;
            dig_idx_q <= '0;
        end else begin
            if (state_q == ACCUMULATE && in_fire) begin
                if (add_full[SUM_WIDTH]) overflow <= 1'b1;
`ifdef DAY10_ACCUM_SATURATE_EN
                sum_q <= add_full[SUM_WIDTH] ? '1 : add_full[SUM_WIDTH-1:0];
`else
                sum_q <= add_full[SUM_WIDTH-1:0];
`endif
            end
            if (state_q == CONVERT && conv_valid) dig_idx_q <= first_idx;
            else if (state_q == EMIT_DIGITS && out_fire && dig_idx_q != '0)
                dig_idx_q <= dig_idx_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_day10_result_accumulator.sv
// Randomized bench: a 32-bit and an 8-bit-sum instance share input stimulus; a decimal-string model checks both.
module tb_day10_result_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic [7:0] in_data  = '0;
    logic       rdy [2];

    axi_stream_if #(.DATA_WIDTH(8)) in_a ();
    axi_stream_if #(.DATA_WIDTH(8)) out_a ();
    axi_stream_if #(.DATA_WIDTH(8)) in_b ();
    axi_stream_if #(.DATA_WIDTH(8)) out_b ();

    logic       ovf [2];
    logic       dn [2];
    logic       i_ready [2];
    logic       o_valid [2];
    logic       o_last [2];
    logic [7:0] o_data [2];

    assign in_a.tvalid = in_valid;
    assign in_a.tlast  = in_last;
    assign in_a.tdata  = in_data;
    assign in_b.tvalid = in_valid;
    assign in_b.tlast  = in_last;
    assign in_b.tdata  = in_data;
    assign out_a.tready = rdy[0];
    assign out_b.tready = rdy[1];

    assign i_ready[0] = in_a.tready;
    assign i_ready[1] = in_b.tready;
    assign o_valid[0] = out_a.tvalid;
    assign o_valid[1] = out_b.tvalid;
    assign o_last[0]  = out_a.tlast;
    assign o_last[1]  = out_b.tlast;
    assign o_data[0]  = out_a.tdata;
    assign o_data[1]  = out_b.tdata;

    day10_result_accumulator #(
        .AXI_DATA_WIDTH (8),
        .SUM_WIDTH      (32)
    ) dut_w32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (in_a),
        .data_out (out_a),
        .overflow (ovf[0]),
        .done     (dn[0])
    );

    day10_result_accumulator #(
        .AXI_DATA_WIDTH (8),
        .SUM_WIDTH      (8)
    ) dut_w8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (in_b),
        .data_out (out_b),
        .overflow (ovf[1]),
        .done     (dn[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          cur[$];
    int          sum_w [2] = '{32, 8};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic total of the frame rendered as decimal text.
    function automatic string model(input int w, output bit ov);
        longint unsigned total = 0;
        longint unsigned maxv  = (64'd1 << w) - 1;
        ov = 1'b0;
        foreach (cur[i]) begin
            total += longint'(cur[i]);
            if (total > maxv) begin
                ov = 1'b1;
`ifdef DAY10_ACCUM_SATURATE_EN
                total = maxv;
`else
                total -= (maxv + 1);
`endif
            end
        end
        return $sformatf("%0d\n", total);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rdy[0]   = 1'b0;
        rdy[1]   = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_eq("rst_ready_low", i_ready[d], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("post_rst_ready", i_ready[d], 1);
            check_eq("post_rst_valid", o_valid[d], 0);
            check_eq("post_rst_done", dn[d], 0);
            check_eq("post_rst_ovf", ovf[d], 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_beats(input bit junk);
        foreach (cur[i]) begin
            int gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(cur[i]);
            in_last  = (i == cur.size() - 1);
            @(negedge clk);
            check_eq("in_ready_acc", {i_ready[0], i_ready[1]}, 2'b11);
            @(posedge clk); #1;
        end
        in_valid = junk;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic collect(input int d, input string exp, input int mode, input bit ov_exp);
        int         n = 0;
        int         idx = 0;
        bit         fin = 1'b0;
        bit         seen = 1'b0;
        bit         stalled = 1'b0;
        bit         r;
        logic [7:0] held = '0;
        logic [7:0] eb;
        while (!fin && n < 300) begin
            @(negedge clk);
            n++;
            check_eq("in_ready_busy", i_ready[d], 0);
            if (stalled) begin
                check_eq("stall_valid", o_valid[d], 1);
                check_eq("stall_data", o_data[d], held);
            end
            if (o_valid[d] && !seen) begin
                seen = 1'b1;
                check_eq($sformatf("latency_w%0d", sum_w[d]), n, sum_w[d] + 3);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (n % 2 == 0);
                default: r = 1'($urandom);
            endcase
            rdy[d] = r;
            if (o_valid[d] && r) begin
                eb = (idx < exp.len()) ? exp[idx] : 8'hFF;
                check_eq($sformatf("byte%0d_w%0d", idx, sum_w[d]), o_data[d], eb);
                check_eq("tlast", o_last[d], idx == exp.len() - 1);
                if (o_last[d]) fin = 1'b1;
                idx++;
                stalled = 1'b0;
            end else if (o_valid[d]) begin
                stalled = 1'b1;
                held    = o_data[d];
            end else begin
                stalled = 1'b0;
            end
        end
        if (!fin) check_eq("output_timeout", 0, 1);
        @(negedge clk);
        rdy[d] = 1'b0;
        check_eq("done_flag", dn[d], 1);
        check_eq("done_valid", o_valid[d], 0);
        check_eq("done_ready", i_ready[d], 0);
        check_eq($sformatf("overflow_w%0d", sum_w[d]), ovf[d], ov_exp);
    endtask

    task automatic run_frame(input int mode, input bit junk, input bit rst_first);
        string s0, s1;
        bit    ov0, ov1;
        if (rst_first) do_reset();
        s0 = model(32, ov0);
        s1 = model(8, ov1);
        drive_beats(junk);
        fork
            collect(0, s0, mode, ov0);
            collect(1, s1, mode, ov1);
        join
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        bit got_valid;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;

        cur = '{2, 3, 5};     run_frame(0, 0, 1);
        cur = '{0};           run_frame(0, 0, 1);
        cur = '{7, 9};        run_frame(1, 0, 1);
        cur = '{200, 100};    run_frame(0, 1, 1);
        cur = '{255, 255, 255, 255}; run_frame(2, 1, 1);

        for (int f = 0; f < 16; f++) begin
            int len = $urandom_range(1, 6);
            cur.delete();
            for (int k = 0; k < len; k++) cur.push_back(int'($urandom_range(0, 255)));
            run_frame($urandom_range(0, 2), 1'($urandom), 1);
        end

        // Reset while both instances are stalled mid-emission, then a clean frame.
        cur = '{250, 250, 250};
        do_reset();
        drive_beats(0);
        in_valid  = 1'b0;
        got_valid = 1'b0;
        for (int c = 0; c < 80 && !got_valid; c++) begin
            @(negedge clk);
            got_valid = o_valid[0];
        end
        check_eq("mid_emit_reached", got_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", {i_ready[0], i_ready[1]}, 2'b00);
        @(posedge clk); #1;
        check_eq("mid_rst_valid_drop", {o_valid[0], o_valid[1]}, 2'b00);
        check_eq("mid_rst_done", {dn[0], dn[1]}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready_back", {i_ready[0], i_ready[1]}, 2'b11);
        check_eq("mid_rst_ovf", {ovf[0], ovf[1]}, 2'b00);
        @(posedge clk); #1;
        cur = '{42};
        run_frame(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timeout");
    end

endmodule
